// File: rtl/div_hilo_sequencer_pkg.sv
// div_hilo_sequencer_pkg
//   Shared definitions for the HI/LO divide sequencer:
//   - the sequencer state encoding
//   - the default operand width
//   - the LO value committed on divide-by-zero
//   - a conditional two's-complement negate helper
package div_hilo_sequencer_pkg;

  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIXUP = 2'd3
  } state_t;

  localparam logic [DEF_WIDTH-1:0] DIV0_LO = {DEF_WIDTH{1'b1}};

  // Two's-complement negate modulo 2^DEF_WIDTH when enable is set.
  // Negating the most negative value returns it unchanged, which is
  // exactly the unsigned magnitude 2^(DEF_WIDTH-1).
  function automatic logic [DEF_WIDTH-1:0] cond_negate(
    input logic [DEF_WIDTH-1:0] value,
    input logic                 enable
  );
    logic [DEF_WIDTH-1:0] result;
    if (enable) begin
      result = ~value + {{(DEF_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/div_hilo_sequencer_if.sv
// div_hilo_sequencer_if
//   Bundles every non-clock signal of the divide sequencer.
//   Datapath request side:
//     start, is_signed, dividend, divisor, hi_we, lo_we, hl_wdata
//   Divider core side:
//     core_m, core_q (operands out), core_quotient, core_remainder (results in)
//   Status and architectural registers:
//     busy, done, div_by_zero, hi, lo
//   Modports:
//     slave  - the sequencer itself
//     master - the surrounding datapath plus the combinational core
interface div_hilo_sequencer_if
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hl_wdata;
  logic [WIDTH-1:0] core_m;
  logic [WIDTH-1:0] core_q;
  logic [WIDTH-1:0] core_quotient;
  logic [WIDTH-1:0] core_remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport slave (
    input  start, is_signed, dividend, divisor, hi_we, lo_we, hl_wdata,
    input  core_quotient, core_remainder,
    output core_m, core_q, busy, done, div_by_zero, hi, lo
  );

  modport master (
    output start, is_signed, dividend, divisor, hi_we, lo_we, hl_wdata,
    output core_quotient, core_remainder,
    input  core_m, core_q, busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix
//   Combinational sign handling around the unsigned divider core.
//
//   Entry side (request operands):
//     is_signed, dividend, divisor -> mag_dividend, mag_divisor,
//                                     dividend_neg, divisor_neg
//   Exit side (held state):
//     raw_quotient, raw_remainder, held_dividend,
//     held_dividend_neg, held_divisor_neg -> quotient, remainder,
//                                            orig_dividend
//
//   The *_neg flags are already qualified by is_signed, so an unsigned
//   request never negates anything.
module div_sign_fix
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] mag_dividend,
  output logic [WIDTH-1:0] mag_divisor,
  output logic             dividend_neg,
  output logic             divisor_neg,
  input  logic [WIDTH-1:0] raw_quotient,
  input  logic [WIDTH-1:0] raw_remainder,
  input  logic [WIDTH-1:0] held_dividend,
  input  logic             held_dividend_neg,
  input  logic             held_divisor_neg,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] orig_dividend
);

  // Operand magnitudes on entry and result sign restoration on exit.
  always_comb begin
    dividend_neg = is_signed & dividend[WIDTH-1];
    divisor_neg  = is_signed & divisor[WIDTH-1];
    mag_dividend = cond_negate(dividend, dividend_neg);
    mag_divisor  = cond_negate(divisor, divisor_neg);

    // Quotient is negative when the operand signs differ; the remainder
    // follows the dividend's sign.
    quotient  = cond_negate(raw_quotient, held_dividend_neg ^ held_divisor_neg);
    remainder = cond_negate(raw_remainder, held_dividend_neg);

    // Re-negating the held magnitude recovers the dividend's original bits,
    // including the most negative value.
    orig_dividend = cond_negate(held_dividend, held_dividend_neg);
  end

endmodule

// File: rtl/div_hilo_sequencer.sv
// div_hilo_sequencer
//   Sequences a DIV/DIVU through an external combinational unsigned divider
//   core and commits the sign-corrected results into HI (remainder) and
//   LO (quotient). Also services direct MTHI/MTLO writes while idle.
//
//   Ports:
//     clock - rising-edge clock
//     clear - asynchronous active-high reset; aborts any division in flight
//     bus   - div_hilo_sequencer_if.slave (request, core and status signals)
//
//   Timing: a start accepted at edge N produces done=1 in the cycle after
//   edge N+SETTLE_CYCLES+3, independent of the operand values.
module div_hilo_sequencer
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clock,
  input  logic                clear,
  div_hilo_sequencer_if.slave bus
);

  // One spare bit so the counter can always represent SETTLE_CYCLES itself.
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1) + 1;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;

  logic             dvd_neg_r;
  logic             dvs_neg_r;
  logic             div0_r;
  logic [WIDTH-1:0] mag_q_r;
  logic [WIDTH-1:0] mag_m_r;
  logic [WIDTH-1:0] core_q_r;
  logic [WIDTH-1:0] core_m_r;
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;

  logic             accept_s;
  logic             load_s;
  logic             capture_s;
  logic             commit_s;
  logic             cnt_inc_s;
  logic             hi_wr_s;
  logic             lo_wr_s;

  logic [WIDTH-1:0] mag_dvd_s;
  logic [WIDTH-1:0] mag_dvs_s;
  logic             dvd_neg_s;
  logic             dvs_neg_s;
  logic [WIDTH-1:0] quot_fix_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] dvd_orig_s;

  div_sign_fix #(
    .WIDTH(WIDTH)
  ) u_sign_fix (
    .is_signed         (bus.is_signed),
    .dividend          (bus.dividend),
    .divisor           (bus.divisor),
    .mag_dividend      (mag_dvd_s),
    .mag_divisor       (mag_dvs_s),
    .dividend_neg      (dvd_neg_s),
    .divisor_neg       (dvs_neg_s),
    .raw_quotient      (quot_r),
    .raw_remainder     (rem_r),
    .held_dividend     (core_q_r),
    .held_dividend_neg (dvd_neg_r),
    .held_divisor_neg  (dvs_neg_r),
    .quotient          (quot_fix_s),
    .remainder         (rem_fix_s),
    .orig_dividend     (dvd_orig_s)
  );

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    load_s    = 1'b0;
    capture_s = 1'b0;
    commit_s  = 1'b0;
    cnt_inc_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          accept_s = 1'b1;
          state_s  = ST_LOAD;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_LOAD: begin
        load_s  = 1'b1;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // The counter starts at zero on entry, so WAIT spans
        // SETTLE_CYCLES+1 cycles before the core outputs are sampled.
        if (cnt_r == CNT_W'(SETTLE_CYCLES)) begin
          capture_s = 1'b1;
          state_s   = ST_FIXUP;
        end else begin
          cnt_inc_s = 1'b1;
          state_s   = ST_WAIT;
        end
      end
      ST_FIXUP: begin
        commit_s = 1'b1;
        state_s  = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Direct HI/LO writes only land while idle.
    hi_wr_s = (state_r == ST_IDLE) & bus.hi_we;
    lo_wr_s = (state_r == ST_IDLE) & bus.lo_we;
  end

  // Operand conditioning, core drive, settle counter and result capture.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      dvd_neg_r <= 1'b0;
      dvs_neg_r <= 1'b0;
      div0_r    <= 1'b0;
      mag_q_r   <= {WIDTH{1'b0}};
      mag_m_r   <= {WIDTH{1'b0}};
      core_q_r  <= {WIDTH{1'b0}};
      core_m_r  <= {WIDTH{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      quot_r    <= {WIDTH{1'b0}};
      rem_r     <= {WIDTH{1'b0}};
    end else begin
      if (accept_s) begin
        dvd_neg_r <= dvd_neg_s;
        dvs_neg_r <= dvs_neg_s;
        div0_r    <= (bus.divisor == {WIDTH{1'b0}});
        mag_q_r   <= mag_dvd_s;
        mag_m_r   <= mag_dvs_s;
      end
      // core_q/core_m stay put from LOAD until the next accepted request.
      if (load_s) begin
        core_q_r <= mag_q_r;
        core_m_r <= mag_m_r;
      end
      if (load_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if (capture_s) begin
        quot_r <= bus.core_quotient;
        rem_r  <= bus.core_remainder;
      end
    end
  end

  // Architectural HI/LO registers and status outputs.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      busy_r <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
    end else begin
      if (commit_s) begin
        if (div0_r) begin
          // Core output is meaningless for a zero divisor.
          lo_r <= DIV0_LO[WIDTH-1:0];
          hi_r <= dvd_orig_s;
        end else begin
          lo_r <= quot_fix_s;
          hi_r <= rem_fix_s;
        end
      end else begin
        if (hi_wr_s) begin
          hi_r <= bus.hl_wdata;
        end
        if (lo_wr_s) begin
          lo_r <= bus.hl_wdata;
        end
      end
      busy_r <= (state_s != ST_IDLE);
      done_r <= commit_s;
      if (accept_s) begin
        dbz_r <= 1'b0;
      end else if (commit_s) begin
        dbz_r <= div0_r;
      end
    end
  end

  assign bus.core_q      = core_q_r;
  assign bus.core_m      = core_m_r;
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.div_by_zero = dbz_r;

endmodule
